// File: rtl/lsh_pkg.sv
// Shared constants and types for the LSH ROM read sequencer.
package lsh_pkg;

   localparam int unsigned LSH_ADDR_W    = 24;
   localparam int unsigned LSH_DATA_W    = 96;
   localparam int unsigned LSH_CNT_W     = 24;
   localparam int unsigned LSH_ROM_DEPTH = 9622800;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StFin
   } lsh_state_e;

   typedef struct packed {
      logic [LSH_DATA_W-1:0] data;
      logic                  last;
   } lsh_word_t;

endpackage

// File: rtl/lsh_resp_fifo.sv
// Response buffer: synchronous FIFO with occupancy output; head is read straight from storage flops.
module lsh_resp_fifo
   import lsh_pkg::*;
#(
   parameter int unsigned Width = $bits(lsh_word_t),
   parameter int unsigned Depth = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [Width-1:0]        wdata_i,
   input  logic                    pop_i,
   output logic [Width-1:0]        rdata_o,
   output logic                    valid_o,
   output logic [$clog2(Depth):0]  occ_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [PtrW:0]    occ_q, occ_d;
   logic             do_pop;

   assign do_pop = pop_i && (occ_q != '0);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push_i) begin
         mem_d[wr_q] = wdata_i;
         wr_d        = wr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + PtrW'(1);
      end
      occ_d = occ_q + (PtrW+1)'(push_i) - (PtrW+1)'(do_pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(Depth); i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   assign rdata_o = mem_q[rd_q];
   assign valid_o = (occ_q != '0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/lsh_rom_reader.sv
// Burst read sequencer for the LSH weight/hash ROM with credit-checked response buffering.
// Optional command bounds check against ROM_DEPTH is enabled by defining LSH_READER_BOUNDS_EN.
module lsh_rom_reader
   import lsh_pkg::*;
#(
   parameter int unsigned ADDR_W     = LSH_ADDR_W,
   parameter int unsigned DATA_W     = LSH_DATA_W,
   parameter int unsigned CNT_W      = LSH_CNT_W,
`ifdef LSH_READER_BOUNDS_EN
   parameter int unsigned ROM_DEPTH  = LSH_ROM_DEPTH,
`endif
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [CNT_W-1:0]  cmd_count,
   output logic              rom_me,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [DATA_W-1:0] rom_q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              cmd_err
);

   localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;

   lsh_state_e        state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rom_me_q, rom_me_d;
   logic              me_last_q, me_last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  left_q, left_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              inflight_q, inflight_last_q;

   logic              accept, reject, credit, pop, head_last;
   logic [OccW-1:0]   occ;
   logic [OccW:0]     pending;
   logic [DATA_W:0]   head;

   assign accept = cmd_valid && cmd_ready_q;

`ifdef LSH_READER_BOUNDS_EN
   localparam int unsigned BndW = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;
   logic [BndW-1:0] base_ext, end_ext;
   assign base_ext = BndW'(cmd_base);
   assign end_ext  = base_ext + BndW'(cmd_count);
   assign reject   = (base_ext >= BndW'(ROM_DEPTH)) || (end_ext > BndW'(ROM_DEPTH));
`else
   assign reject = 1'b0;
`endif

   // A read already on rom_me lands in the FIFO two cycles later, so it holds a credit too.
   assign pending = {1'b0, occ} + {{OccW{1'b0}}, inflight_q} + {{OccW{1'b0}}, rom_me_q};
   assign credit  = pending < (OccW+1)'(FIFO_DEPTH);

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      rom_me_d    = 1'b0;
      me_last_d   = 1'b0;
      addr_d      = addr_q;
      left_d      = left_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               cmd_ready_d = 1'b0;
               if (reject) begin
                  state_d = StFin;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (cmd_count == '0) begin
                  state_d = StFin;
                  done_d  = 1'b1;
               end else begin
                  rom_me_d  = 1'b1;
                  addr_d    = cmd_base;
                  left_d    = cmd_count - CNT_W'(1);
                  me_last_d = (cmd_count == CNT_W'(1));
                  state_d   = me_last_d ? StDrain : StIssue;
               end
            end
         end
         StIssue: begin
            if (credit) begin
               rom_me_d  = 1'b1;
               addr_d    = addr_q + ADDR_W'(1);
               left_d    = left_q - CNT_W'(1);
               me_last_d = (left_q == CNT_W'(1));
               if (me_last_d) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            // Popping the tagged last word implies the buffer and read pipe are empty.
            if (pop && head_last) begin
               state_d = StFin;
               done_d  = 1'b1;
            end
         end
         StFin: begin
            state_d     = StIdle;
            cmd_ready_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= StIdle;
         cmd_ready_q     <= 1'b0;
         rom_me_q        <= 1'b0;
         me_last_q       <= 1'b0;
         addr_q          <= '0;
         left_q          <= '0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cmd_ready_q     <= (state_q == StIdle) ? cmd_ready_d | ~accept : cmd_ready_d;
         rom_me_q        <= rom_me_d;
         me_last_q       <= me_last_d;
         addr_q          <= addr_d;
         left_q          <= left_d;
         done_q          <= done_d;
         err_q           <= err_d;
         inflight_q      <= rom_me_q;
         inflight_last_q <= me_last_q;
      end
   end

   lsh_resp_fifo #(
      .Width (DATA_W + 1),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (inflight_q),
      .wdata_i ({rom_q, inflight_last_q}),
      .pop_i   (pop),
      .rdata_o (head),
      .valid_o (out_valid),
      .occ_o   (occ)
   );

   assign pop         = out_valid && out_ready;
   assign head_last   = head[0];
   assign out_data    = head[DATA_W:1];
   assign out_last    = out_valid && head_last;
   assign cmd_ready   = cmd_ready_q;
   assign rom_me      = rom_me_q;
   assign rom_address = addr_q;
   assign done        = done_q;
   assign cmd_err     = err_q;

endmodule

// File: tb/tb_lsh_rom_reader.sv
// Directed self-checking bench for lsh_rom_reader with a registered ROM model.
module tb_lsh_rom_reader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [23:0] cmd_base = '0;
   logic [23:0] cmd_count = '0;
   logic        rom_me;
   logic [23:0] rom_address;
   logic [95:0] rom_q;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [95:0] out_data;
   logic        out_last;
   logic        done;
   logic        cmd_err;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [23:0] addr_log[$];
   int          addr_cyc[$];
   logic [95:0] pop_data[$];
   logic        pop_last[$];
   int          pop_cyc[$];
   int          done_cyc[$];
   int          err_cyc[$];
   int          issued, popped, max_out, stall_bad;
   logic        prev_stall = 1'b0;
   logic [95:0] prev_data;
   logic        prev_last;

   lsh_rom_reader u_dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_base    (cmd_base),
      .cmd_count   (cmd_count),
      .rom_me      (rom_me),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .done        (done),
      .cmd_err     (cmd_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [95:0] rom_word(input logic [23:0] a);
      return {a, ~a, a ^ 24'h5A5A5A, a + 24'd7};
   endfunction

   // Junk on idle cycles so a stray push is visible.
   always @(posedge clock) rom_q <= rom_me ? rom_word(rom_address) : {3{32'hBAD0_BAD0}};

   always @(negedge clock) begin
      if (done) done_cyc.push_back(cyc);
      if (cmd_err) err_cyc.push_back(cyc);
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (rom_me) begin
            issued++;
            addr_log.push_back(rom_address);
            addr_cyc.push_back(cyc);
         end
         if (issued - popped > max_out) max_out = issued - popped;
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_bad++;
         if (out_valid && out_ready) begin
            popped++;
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
            pop_cyc.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic clr_log();
      addr_log.delete(); addr_cyc.delete(); pop_data.delete(); pop_last.delete();
      pop_cyc.delete(); done_cyc.delete(); err_cyc.delete();
      issued = 0; popped = 0; max_out = 0; stall_bad = 0;
   endtask

   // Called at posedge+1 with the DUT idle; returns t = acceptance cycle T.
   task automatic send(input logic [23:0] b, input logic [23:0] c, output int t);
      cmd_base = b; cmd_count = c; cmd_valid = 1'b1;
      @(posedge clock); #1;
      t = cyc - 1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
      n_cmp++; if (rom_me !== 1'b0) begin n_fail++; $display("FAIL rst_rom_me: got %b want 0", rom_me); end
      n_cmp++; if (rom_address !== 24'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", rom_address); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      n_cmp++; if (out_data !== 96'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      n_cmp++; if ({done, cmd_err} !== 2'b00) begin n_fail++; $display("FAIL rst_done_err: got %b want 00", {done, cmd_err}); end
      reset = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_idle_ready: got %b want 1", cmd_ready); end
   endtask

   task automatic test_basic();
      int t;
      out_ready = 1'b1;
      clr_log();
      send(24'h000010, 24'd5, t);
      for (int i = 0; i < 100 && done_cyc.size() == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (addr_log.size() != 5) begin n_fail++; $display("FAIL basic_nreads: got %0d want 5", addr_log.size()); end
      n_cmp++; if (pop_data.size() != 5) begin n_fail++; $display("FAIL basic_npops: got %0d want 5", pop_data.size()); end
      for (int i = 0; i < 5 && i < addr_log.size() && i < pop_data.size(); i++) begin
         n_cmp++;
         if (addr_log[i] !== 24'h10 + 24'(i) || addr_cyc[i] != t + 1 + i) begin
            n_fail++;
            $display("FAIL basic_addr%0d: got %h@%0d want %h@%0d", i, addr_log[i], addr_cyc[i], 24'h10 + 24'(i), t + 1 + i);
         end
         n_cmp++;
         if (pop_data[i] !== rom_word(24'h10 + 24'(i)) || pop_cyc[i] != t + 3 + i || pop_last[i] !== (i == 4)) begin
            n_fail++;
            $display("FAIL basic_word%0d: got %h last=%b @%0d want %h last=%b @%0d", i, pop_data[i], pop_last[i],
                     pop_cyc[i], rom_word(24'h10 + 24'(i)), (i == 4), t + 3 + i);
         end
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 8) begin
         n_fail++; $display("FAIL basic_done: got n=%0d @%0d want n=1 @%0d", done_cyc.size(), done_cyc[0], t + 8);
      end
   endtask

   task automatic test_zero();
      int t;
      clr_log();
      send(24'h000055, 24'd0, t);
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready_t1: got %b want 0", cmd_ready); end
      @(posedge clock); #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_t2: got %b want 1", cmd_ready); end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 1) begin
         n_fail++; $display("FAIL zero_done: got n=%0d @%0d want n=1 @%0d", done_cyc.size(), done_cyc[0], t + 1);
      end
      n_cmp++; if (addr_log.size() != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", addr_log.size()); end
   endtask

   task automatic test_stall();
      int t;
      out_ready = 1'b0;
      clr_log();
      send(24'h000200, 24'd20, t);
      for (int k = 0; k < 600 && done_cyc.size() == 0; k++) begin
         out_ready = (k % 3 == 0);
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (pop_data.size() != 20) begin n_fail++; $display("FAIL stall_npops: got %0d want 20", pop_data.size()); end
      n_cmp++; if (addr_log.size() != 20) begin n_fail++; $display("FAIL stall_nreads: got %0d want 20", addr_log.size()); end
      for (int i = 0; i < 20 && i < pop_data.size(); i++) begin
         n_cmp++;
         if (pop_data[i] !== rom_word(24'h200 + 24'(i)) || pop_last[i] !== (i == 19)) begin
            n_fail++;
            $display("FAIL stall_word%0d: got %h last=%b want %h last=%b", i, pop_data[i], pop_last[i],
                     rom_word(24'h200 + 24'(i)), (i == 19));
         end
      end
      n_cmp++; if (max_out > 4) begin n_fail++; $display("FAIL stall_credit: got %0d outstanding want <=4", max_out); end
      n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes want 0", stall_bad); end
      n_cmp++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_cyc.size()); end
   endtask

`ifndef LSH_READER_BOUNDS_EN
   task automatic test_wrap();
      int t;
      logic [23:0] exp_a [4];
      exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
      out_ready = 1'b1;
      clr_log();
      send(24'hFFFFFE, 24'd4, t);
      for (int i = 0; i < 100 && done_cyc.size() == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (addr_log.size() != 4) begin n_fail++; $display("FAIL wrap_nreads: got %0d want 4", addr_log.size()); end
      for (int i = 0; i < 4 && i < addr_log.size() && i < pop_data.size(); i++) begin
         n_cmp++;
         if (addr_log[i] !== exp_a[i] || pop_data[i] !== rom_word(exp_a[i])) begin
            n_fail++;
            $display("FAIL wrap_%0d: got addr %h data %h want addr %h data %h", i, addr_log[i], pop_data[i],
                     exp_a[i], rom_word(exp_a[i]));
         end
      end
      n_cmp++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL wrap_err: got %0d want 0", err_cyc.size()); end
   endtask
`else
   task automatic test_bounds();
      int t;
      out_ready = 1'b1;
      clr_log();
      send(24'd9622798, 24'd4, t);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if (err_cyc.size() != 1 || err_cyc[0] != t + 1) begin
         n_fail++; $display("FAIL bnd_err: got n=%0d @%0d want n=1 @%0d", err_cyc.size(), err_cyc[0], t + 1);
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 1) begin
         n_fail++; $display("FAIL bnd_done: got n=%0d @%0d want n=1 @%0d", done_cyc.size(), done_cyc[0], t + 1);
      end
      n_cmp++; if (addr_log.size() != 0) begin n_fail++; $display("FAIL bnd_reads: got %0d want 0", addr_log.size()); end
      clr_log();
      send(24'd9622796, 24'd4, t);
      for (int i = 0; i < 100 && done_cyc.size() == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (pop_data.size() != 4) begin n_fail++; $display("FAIL bnd_ok_pops: got %0d want 4", pop_data.size()); end
      n_cmp++; if (err_cyc.size() != 0) begin n_fail++; $display("FAIL bnd_ok_err: got %0d want 0", err_cyc.size()); end
   endtask
`endif

   task automatic test_reset_mid();
      int t;
      out_ready = 1'b0;
      clr_log();
      send(24'h000300, 24'd10, t);
      n_cmp++; if (rom_me !== 1'b1) begin n_fail++; $display("FAIL rmid_me: got %b want 1", rom_me); end
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++; if ({rom_me, out_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_clear: got %b want 00", {rom_me, out_valid}); end
      reset = 1'b0;
      @(posedge clock); #1;
      n_cmp++; if (done_cyc.size() != 0) begin n_fail++; $display("FAIL rmid_nodone: got %0d want 0", done_cyc.size()); end
      out_ready = 1'b1;
      clr_log();
      send(24'h000100, 24'd2, t);
      for (int i = 0; i < 100 && done_cyc.size() == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (pop_data.size() != 2) begin n_fail++; $display("FAIL rmid_npops: got %0d want 2", pop_data.size()); end
      for (int i = 0; i < 2 && i < pop_data.size(); i++) begin
         n_cmp++;
         if (pop_data[i] !== rom_word(24'h100 + 24'(i)) || pop_last[i] !== (i == 1)) begin
            n_fail++;
            $display("FAIL rmid_word%0d: got %h last=%b want %h last=%b", i, pop_data[i], pop_last[i],
                     rom_word(24'h100 + 24'(i)), (i == 1));
         end
      end
   endtask

   task automatic test_cmd_ignore();
      int t;
      int busy_bad = 0;
      out_ready = 1'b1;
      clr_log();
      send(24'h000400, 24'd6, t);
      cmd_valid = 1'b1; cmd_base = 24'h000999; cmd_count = 24'd3;
      for (int i = 0; i < 4; i++) begin
         if (cmd_ready !== 1'b0) busy_bad++;
         @(posedge clock); #1;
      end
      cmd_valid = 1'b0;
      n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL ign_ready: got %0d high cycles want 0", busy_bad); end
      for (int i = 0; i < 100 && done_cyc.size() == 0; i++) @(posedge clock);
      repeat (3) @(posedge clock);
      #1;
      n_cmp++; if (addr_log.size() != 6) begin n_fail++; $display("FAIL ign_nreads: got %0d want 6", addr_log.size()); end
      for (int i = 0; i < 6 && i < addr_log.size() && i < pop_data.size(); i++) begin
         n_cmp++;
         if (addr_log[i] !== 24'h400 + 24'(i) || pop_data[i] !== rom_word(24'h400 + 24'(i))) begin
            n_fail++;
            $display("FAIL ign_%0d: got addr %h data %h want addr %h", i, addr_log[i], pop_data[i], 24'h400 + 24'(i));
         end
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 9) begin
         n_fail++; $display("FAIL ign_done: got n=%0d @%0d want n=1 @%0d", done_cyc.size(), done_cyc[0], t + 9);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_stall();
`ifndef LSH_READER_BOUNDS_EN
      test_wrap();
`else
      test_bounds();
`endif
      test_reset_mid();
      test_cmd_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
